div_repsub: RTL

Sequential unsigned divider using repeated subtraction: the inverse companion of the team's repeated-addition multiplier, built in the same controller/datapath style. It accepts a dividend and divisor on a start pulse, subtracts the divisor once per clock until the running remainder is smaller than it, and then presents quotient and remainder with a one-cycle done pulse. It sits beside the multiplier as a small arithmetic engine for non-time-critical datapaths.

---
 rtl/div_pkg.sv | 13 +
 rtl/div_repsub_if.sv | 28 ++
 rtl/div_datapath.sv | 67 ++++++
 rtl/div_repsub.sv | 79 +++++++
 4 files changed

// File: rtl/div_pkg.sv
// div_pkg: shared types and constants for the repeated-subtraction divider.
package div_pkg;

  localparam int DEFAULT_WIDTH = 16;

  // Controller states with a fixed 2-bit encoding.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    SUB  = 2'b01,
    DONE = 2'b10
  } state_t;

endpackage

// File: rtl/div_repsub_if.sv
// div_repsub_if: request/result bundle for the divider.
// Handshake: start is a request. It is taken on a rising edge only while busy
// is low (state IDLE) and is never queued. done is a one-cycle pulse. quotient,
// remainder and div_by_zero stay stable from done until the next accepted start.
// state is a debug view of the controller.
interface div_repsub_if import div_pkg::*; #(parameter int WIDTH = DEFAULT_WIDTH);

  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;
  state_t           state;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero, state
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero, state
  );

endinterface

// File: rtl/div_datapath.sv
// div_datapath: R/D/Q registers, R>=D comparator, subtractor, Q incrementer
// and zero-divisor detect. Optional registered div_by_zero flag under the
// DIV_ZERO_FLAG_EN macro (tied low otherwise).
module div_datapath #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             force_res,
  input  logic             sub,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             ge,
  output logic             zero,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             flag
);

  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] d_q;
  logic [WIDTH-1:0] q_q;

  assign zero = (divisor == '0);

  // A zero divisor is stored as D=0; masking ge on it makes the controller
  // leave SUB after one cycle with the forced result untouched.
  assign ge = (d_q != '0) && (r_q >= d_q);

  assign quotient  = q_q;
  assign remainder = r_q;

  // Operand capture on accept, then one subtract/increment step per cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= '0;
      d_q <= '0;
      q_q <= '0;
    end else if (load) begin
      r_q <= dividend;
      d_q <= divisor;
      q_q <= force_res ? '1 : '0;
    end else if (sub) begin
      r_q <= r_q - d_q;
      q_q <= q_q + WIDTH'(1);
    end
  end

`ifdef DIV_ZERO_FLAG_EN
  logic flag_q;

  // Flag follows the divisor class of the most recent accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flag_q <= 1'b0;
    end else if (load) begin
      flag_q <= force_res;
    end
  end

  assign flag = flag_q;
`else
  assign flag = 1'b0;
`endif

endmodule

// File: rtl/div_repsub.sv
// div_repsub: sequential unsigned divider by repeated subtraction.
// Controller FSM (IDLE/SUB/DONE) here, arithmetic in div_datapath.
// Optional feature macro: DIV_ZERO_FLAG_EN (registered div_by_zero flag).
module div_repsub import div_pkg::*; #(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input logic         clk,
  input logic         rst_n,
  div_repsub_if.slave bus
);

  state_t state;
  state_t state_nx;
  logic   load;
  logic   force_res;
  logic   sub;
  logic   ge;
  logic   zero;

  div_datapath #(.WIDTH(WIDTH)) u_dp (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load),
    .force_res (force_res),
    .sub       (sub),
    .dividend  (bus.dividend),
    .divisor   (bus.divisor),
    .ge        (ge),
    .zero      (zero),
    .quotient  (bus.quotient),
    .remainder (bus.remainder),
    .flag      (bus.div_by_zero)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state and datapath controls. A zero divisor loads the forced
  // result and spends its one SUB cycle idle (ge is masked).
  always_comb begin
    state_nx  = state;
    load      = 1'b0;
    force_res = 1'b0;
    sub       = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          load      = 1'b1;
          force_res = zero;
          state_nx  = SUB;
        end
      end
      SUB: begin
        if (ge) begin
          sub = 1'b1;
        end else begin
          state_nx = DONE;
        end
      end
      DONE: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  assign bus.busy  = (state != IDLE);
  assign bus.done  = (state == DONE);
  assign bus.state = state;

endmodule
